// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Optional accumulate mode is selected with MULT_ACC_EN.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ACC  = 2'd3
    } mult_state_t;

    localparam int MULT_WIDTH_DEF     = 8;
    localparam int MULT_ACC_GUARD_DEF = 4;

    // Result width: plain product, or product plus accumulator guard bits.
    function automatic int res_width(input int w, input int g, input bit acc_en);
        return acc_en ? (2 * w + g) : (2 * w);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand and result handshakes of the sequential multiplier.
// acc_clr_i exists only when MULT_ACC_EN is defined.
interface mult_seq_ctrl_if import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH_DEF,
    parameter int RES_W = 2 * MULT_WIDTH_DEF
) ();

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
`ifdef MULT_ACC_EN
    logic             acc_clr_i;
`endif
    logic             out_valid_o;
    logic             out_ready_i;
    logic [RES_W-1:0] result_o;

    modport master (
        output in_valid_i, a_i, b_i,
`ifdef MULT_ACC_EN
        output acc_clr_i,
`endif
        output out_ready_i,
        input  in_ready_o, out_valid_o, result_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i,
`ifdef MULT_ACC_EN
        input  acc_clr_i,
`endif
        input  out_ready_i,
        output in_ready_o, out_valid_o, result_o
    );

endinterface

// File: rtl/mult_core.sv
// One multiplier cell: gates a multiplicand bit with the current
// multiplier bit and adds it to a partial-product bit with ripple carry.
module mult_core (
    input  logic a_i,
    input  logic b_i,
    input  logic pp_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    assign p   = a_i & b_i;
    assign s_o = pp_i ^ p ^ c_i;
    assign c_o = (pp_i & p) | (c_i & (pp_i ^ p));

endmodule

// File: rtl/mult_row.sv
// One WIDTH-wide add row: {cout, sum} = pp_hi + (a & {WIDTH{b_bit}}),
// built as a ripple chain of mult_core cells from LSB to MSB.
module mult_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_bit_i,
    input  logic [WIDTH-1:0] pp_hi_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mult_core u_core (
            .a_i  (a_i[i]),
            .b_i  (b_bit_i),
            .pp_i (pp_hi_i[i]),
            .c_i  (c[i]),
            .s_o  (sum_o[i]),
            .c_o  (c[i+1])
        );
    end

    assign cout_o = c[WIDTH];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller, one multiplier bit per cycle.
// Define MULT_ACC_EN to add the accumulate stage (ACC state, acc_clr_i).
module mult_seq_ctrl import mult_pkg::*; #(
    parameter int WIDTH     = MULT_WIDTH_DEF,
    parameter int ACC_GUARD = MULT_ACC_GUARD_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mult_seq_ctrl_if.slave bus,
    output logic           busy_o
);

`ifdef MULT_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(WIDTH);
    localparam int RES_W = res_width(WIDTH, ACC_GUARD, ACC_EN);

    mult_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] pp_q, pp_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               ovld_q, ovld_d;
`ifdef MULT_ACC_EN
    logic [RES_W-1:0]   acc_q, acc_d;
    logic               clr_q, clr_d;
`endif

    logic [WIDTH-1:0]   row_sum;
    logic               row_cout;
    logic               last_bit;

    mult_row #(.WIDTH(WIDTH)) u_row (
        .a_i     (a_q),
        .b_bit_i (b_q[cnt_q]),
        .pp_hi_i (pp_q[2*WIDTH-1:WIDTH]),
        .sum_o   (row_sum),
        .cout_o  (row_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        pp_d    = pp_q;
        res_d   = res_q;
        ovld_d  = ovld_q;
`ifdef MULT_ACC_EN
        acc_d   = acc_q;
        clr_d   = clr_q;
`endif
        case (state_q)
            IDLE: begin
                // Reset is handled in the register process, so IDLE alone means ready.
                if (bus.in_valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    pp_d    = '0;
                    cnt_d   = '0;
`ifdef MULT_ACC_EN
                    clr_d   = bus.acc_clr_i;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                pp_d  = {row_cout, row_sum, pp_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
`ifdef MULT_ACC_EN
                    state_d = ACC;
`else
                    res_d   = pp_d;
                    ovld_d  = 1'b1;
                    state_d = DONE;
`endif
                end
            end
`ifdef MULT_ACC_EN
            ACC: begin
                acc_d   = (clr_q ? '0 : acc_q) + RES_W'(pp_q);
                res_d   = acc_d;
                ovld_d  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (ovld_q && bus.out_ready_i) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            ovld_q  <= 1'b0;
`ifdef MULT_ACC_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovld_q  <= ovld_d;
`ifdef MULT_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Operand and partial-product registers are only meaningful after an accept.
    always_ff @(posedge clk_i) begin
        a_q  <= a_d;
        b_q  <= b_d;
        pp_q <= pp_d;
`ifdef MULT_ACC_EN
        clr_q <= clr_d;
`endif
    end

    assign bus.in_ready_o  = !rst_i && (state_q == IDLE);
    assign bus.out_valid_o = ovld_q;
    assign bus.result_o    = res_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl against a plain-arithmetic model.
// Builds with or without MULT_ACC_EN.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    localparam int WIDTH = 8;
`ifdef MULT_ACC_EN
    localparam bit ACC_EN = 1'b1;
    localparam int LAT    = WIDTH + 1;
`else
    localparam bit ACC_EN = 1'b0;
    localparam int LAT    = WIDTH;
`endif
    localparam int RES_W = res_width(WIDTH, 4, ACC_EN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [RES_W-1:0] acc_m = '0;

    mult_seq_ctrl_if #(.WIDTH(WIDTH), .RES_W(RES_W)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .ACC_GUARD(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference: product of the operands, optionally summed into a wrapping accumulator.
    function automatic logic [RES_W-1:0] model_step(input logic [7:0] a, input logic [7:0] b,
                                                     input logic clr);
        logic [RES_W-1:0] prod;
        prod  = RES_W'(int'(a) * int'(b));
        acc_m = (clr ? '0 : acc_m) + prod;
        return ACC_EN ? acc_m : prod;
    endfunction

    task automatic drive_in(input logic v, input logic [7:0] a, input logic [7:0] b, input logic clr);
        bus.in_valid_i = v;
        bus.a_i        = a;
        bus.b_i        = b;
`ifdef MULT_ACC_EN
        bus.acc_clr_i  = clr;
`else
        if (clr === 1'bx) bus.in_valid_i = v;
`endif
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.in_ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready", 32'(bus.in_ready_o), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                         input int hold, input bit early);
        logic [RES_W-1:0] exp_res;
        logic [RES_W-1:0] held;
        int lat;
        wait_ready();
        drive_in(1'b1, a, b, clr);
        bus.out_ready_i = 1'b0;
        @(posedge clk); #1;
        exp_res = model_step(a, b, clr);
        bus.out_ready_i = early;
        lat = 0;
        while (!bus.out_valid_o && lat < 20) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("in_ready_busy", 32'(bus.in_ready_o), 32'd0);
            // Noise on the operand port while busy must be ignored.
            drive_in(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        drive_in(1'b0, 8'($urandom), 8'($urandom), 1'b0);
        chk("latency", 32'(lat), 32'(LAT));
        chk("result", 32'(bus.result_o), 32'(exp_res));
        if (early) begin
            @(posedge clk); #1;
            chk("xfer_early", 32'(bus.out_valid_o), 32'd0);
        end else begin
            held = bus.result_o;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_vld", 32'(bus.out_valid_o), 32'd1);
                chk("hold_res", 32'(bus.result_o), 32'(held));
            end
            bus.out_ready_i = 1'b1;
            @(posedge clk); #1;
            chk("xfer", 32'(bus.out_valid_o), 32'd0);
        end
        chk("idle_busy", 32'(busy), 32'd0);
        bus.out_ready_i = 1'b0;
    endtask

    // Start an operation, then reset after 'edges' clock edges; nothing may come out.
    task automatic abort_op(input logic [7:0] a, input logic [7:0] b, input int edges);
        int seen = 0;
        wait_ready();
        drive_in(1'b1, a, b, 1'b0);
        bus.out_ready_i = 1'b0;
        @(posedge clk); #1;
        drive_in(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (edges) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc_m = '0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(bus.out_valid_o), 32'd0);
        chk("rst_res", 32'(bus.result_o), 32'd0);
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (bus.out_valid_o) seen++;
        end
        chk("rst_no_result", 32'(seen), 32'd0);
    endtask

    initial begin
        bus.out_ready_i = 1'b0;
        drive_in(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_vld", 32'(bus.out_valid_o), 32'd0);
        chk("reset_res", 32'(bus.result_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(bus.in_ready_o), 32'd1);

        do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b1);
        do_op(8'h00, 8'hA5, 1'b1, 0, 1'b0);
        do_op(8'h01, 8'h80, 1'b1, 0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 5, 1'b0);

        abort_op(8'h55, 8'h66, 3);
        do_op(8'h03, 8'h07, 1'b1, 1, 1'b0);

        do_op(8'h03, 8'h04, 1'b1, 0, 1'b0);
        do_op(8'h05, 8'h06, 1'b0, 0, 1'b0);
        do_op(8'h02, 8'h02, 1'b1, 0, 1'b0);

        abort_op(8'h9C, 8'h3B, LAT + 2);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 8'h00;
                1: rb = 8'hFF;
                2: begin ra = 8'hFF; rb = 8'hFF; end
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
